// File: rtl/iq_frame_pkg.sv
// Shared types and helpers for the IQ frame capture block: sample/beat layout,
// capture state encoding and the saturating magnitude function.
package iq_frame_pkg;

    localparam int IQ_W             = 16;
    localparam int SAMPLES_PER_BEAT = 4;
    localparam int BEAT_W           = 2 * IQ_W * SAMPLES_PER_BEAT;

    // Q occupies the upper half of each 32-bit sample slot, I the lower half.
    typedef struct packed {
        logic signed [IQ_W-1:0] q;
        logic signed [IQ_W-1:0] i;
    } iq_sample_t;

    typedef iq_sample_t [SAMPLES_PER_BEAT-1:0] beat_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // |x| with the single unrepresentable case (-32768) clamped to 32767.
    function automatic logic [IQ_W-1:0] abs_sat16(input logic signed [IQ_W-1:0] x);
        logic [IQ_W-1:0] r;
        if (x == 16'sh8000) begin
            r = 16'h7FFF;
        end else if (x[IQ_W-1]) begin
            r = 16'(-x);
        end else begin
            r = 16'(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_frame_ram.sv
// Simple dual-port beat buffer: one write port, one registered read port.
// Same-address read and write in one cycle returns the previous contents.
module iq_frame_ram
    import iq_frame_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [BEAT_W-1:0] rd_data
);

    logic [BEAT_W-1:0] mem_r [DEPTH];
    logic [BEAT_W-1:0] rd_data_r;

    // Storage array; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/iq_frame_capture.sv
// AXI4-Stream sink that aligns to a frame boundary after arm, stores one frame
// of 128-bit IQ beats and reports length, sideband, drops and peak magnitudes.
module iq_frame_capture
    import iq_frame_pkg::*;
#(
    parameter int DEPTH         = 512,
    parameter bit SYNC_ON_TLAST = 1'b1
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic [127:0]             s_axis_tdata,
    input  logic [7:0]               s_axis_tid,
    input  logic                     s_axis_tlast,
    input  logic [7:0]               s_axis_tuser,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     arm,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   frame_len,
    output logic [7:0]               frame_tid,
    output logic [7:0]               frame_tuser,
    output logic [15:0]              peak_i,
    output logic [15:0]              peak_q,
    output logic [15:0]              dropped_cnt,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [127:0]             rd_data
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             LW      = AW + 1;
    localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);

    cap_state_t     state_r, state_n, base_state_s;
    logic           ready_r, busy_r, done_r, done_n, base_done_s;
    logic           ovf_r, ovf_n, base_ovf_s;
    logic [LW-1:0]  len_r, len_n, base_len_s;
    logic [7:0]     tid_r, tid_n, tuser_r, tuser_n;
    logic [15:0]    pi_r, pi_n, base_pi_s, pq_r, pq_n, base_pq_s;
    logic [15:0]    drop_r, drop_n, base_drop_s, drop_inc_s;
    logic [15:0]    beat_pi_s, beat_pq_s;
    logic           accept_s, wr_en_s;
    beat_t          beat_s;

    assign accept_s = s_axis_tvalid & ready_r;
    assign beat_s   = beat_t'(s_axis_tdata);

    // Largest |I| and |Q| among the four samples of the incoming beat.
    always_comb begin
        beat_pi_s = 16'd0;
        beat_pq_s = 16'd0;
        for (int k = 0; k < SAMPLES_PER_BEAT; k++) begin
            beat_pi_s = (abs_sat16(beat_s[k].i) > beat_pi_s) ? abs_sat16(beat_s[k].i) : beat_pi_s;
            beat_pq_s = (abs_sat16(beat_s[k].q) > beat_pq_s) ? abs_sat16(beat_s[k].q) : beat_pq_s;
        end
    end

    // An arm takes effect first, so a beat in the same cycle sees the restarted capture.
    always_comb begin
        base_state_s = state_r;
        base_len_s   = len_r;
        base_drop_s  = drop_r;
        base_pi_s    = pi_r;
        base_pq_s    = pq_r;
        base_done_s  = done_r;
        base_ovf_s   = ovf_r;
        if (arm) begin
            base_state_s = SYNC_ON_TLAST ? ST_SYNC : ST_CAPTURE;
            base_len_s   = '0;
            base_drop_s  = 16'd0;
            base_pi_s    = 16'd0;
            base_pq_s    = 16'd0;
            base_done_s  = 1'b0;
            base_ovf_s   = 1'b0;
        end else begin
            base_state_s = state_r;
        end
    end

    // Next-state and counter update for one accepted beat.
    always_comb begin
        state_n    = base_state_s;
        len_n      = base_len_s;
        drop_n     = base_drop_s;
        pi_n       = base_pi_s;
        pq_n       = base_pq_s;
        done_n     = base_done_s;
        ovf_n      = base_ovf_s;
        tid_n      = tid_r;
        tuser_n    = tuser_r;
        wr_en_s    = 1'b0;
        drop_inc_s = (base_drop_s == 16'hFFFF) ? base_drop_s : base_drop_s + 16'd1;
        if (accept_s) begin
            case (base_state_s)
                ST_CAPTURE: begin
                    if (base_len_s == DEPTH_L) begin
                        drop_n  = drop_inc_s;
                        ovf_n   = ~s_axis_tlast;
                        done_n  = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        wr_en_s = 1'b1;
                        len_n   = base_len_s + LW'(1);
                        pi_n    = (beat_pi_s > base_pi_s) ? beat_pi_s : base_pi_s;
                        pq_n    = (beat_pq_s > base_pq_s) ? beat_pq_s : base_pq_s;
                        if (base_len_s == '0) begin
                            tid_n   = s_axis_tid;
                            tuser_n = s_axis_tuser;
                        end else begin
                            tid_n   = tid_r;
                        end
                        if (s_axis_tlast) begin
                            done_n  = 1'b1;
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_CAPTURE;
                        end
                    end
                end
                ST_SYNC: begin
                    drop_n = drop_inc_s;
                    if (s_axis_tlast) begin
                        state_n = ST_CAPTURE;
                    end else begin
                        state_n = ST_SYNC;
                    end
                end
                default: begin
                    drop_n = drop_inc_s;
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // State and status registers.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            len_r   <= '0;
            tid_r   <= 8'd0;
            tuser_r <= 8'd0;
            pi_r    <= 16'd0;
            pq_r    <= 16'd0;
            drop_r  <= 16'd0;
        end else begin
            state_r <= state_n;
            ready_r <= 1'b1;
            busy_r  <= (state_n == ST_SYNC) || (state_n == ST_CAPTURE);
            done_r  <= done_n;
            ovf_r   <= ovf_n;
            len_r   <= len_n;
            tid_r   <= tid_n;
            tuser_r <= tuser_n;
            pi_r    <= pi_n;
            pq_r    <= pq_n;
            drop_r  <= drop_n;
        end
    end

    iq_frame_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (s_axis_aclk),
        .rst_n   (s_axis_aresetn),
        .wr_en   (wr_en_s),
        .wr_addr (base_len_s[AW-1:0]),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign s_axis_tready = ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign overflow      = ovf_r;
    assign frame_len     = len_r;
    assign frame_tid     = tid_r;
    assign frame_tuser   = tuser_r;
    assign peak_i        = pi_r;
    assign peak_q        = pq_r;
    assign dropped_cnt   = drop_r;

endmodule
